// File: rtl/packet_alu_pkg.sv
// Shared types and constants for the packet command processor.
package packet_alu_pkg;

  localparam logic [7:0] OPCODE_ECHO = 8'hEC;
  localparam logic [7:0] OPCODE_ADD  = 8'hAD;
  localparam logic [7:0] OPCODE_SUB  = 8'h5B;
  localparam logic [7:0] OPCODE_MUL  = 8'h88;
  localparam logic [7:0] OPCODE_DIV  = 8'hD1;
  localparam int unsigned HDR_BYTES  = 4;

  typedef enum logic [3:0] {
    StOpcode,
    StReserved,
    StLenLsb,
    StLenMsb,
    StEcho,
    StFirstNumber,
    StRxNumber,
    StAdd,
    StSub,
    StMul,
    StDiv,
    StDivWait,
    StTransmit,
    StDrain
  } state_t;

  function automatic logic is_arith(input logic [7:0] opcode);
    return (opcode == OPCODE_ADD) || (opcode == OPCODE_SUB) ||
           (opcode == OPCODE_MUL) || (opcode == OPCODE_DIV);
  endfunction

  // Only called for opcodes that passed is_arith.
  function automatic state_t op_state(input logic [7:0] opcode);
    case (opcode)
      OPCODE_ADD: return StAdd;
      OPCODE_SUB: return StSub;
      OPCODE_MUL: return StMul;
      default:    return StDiv;
    endcase
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; divisor 0 yields all ones.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] quo_next, rem_next;

  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]};
    fits     = trial >= {1'b0, dvs_q};
    rem_next = fits ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], fits};
  end

  // The final step is presented combinationally so the caller can latch it in the same cycle.
  assign quotient_o = quo_next;
  assign done_o     = busy_q && (cnt_q == CntW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CntW'(WIDTH);
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      quo_q <= quo_next;
      rem_q <= rem_next;
      cnt_q <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/packet_alu.sv
// Framed byte-stream command processor: echo or fold little-endian operands with + - * /.
module packet_alu
  import packet_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LastByte = CW'(BYTES - 1);

  state_t              state_q, state_d;
  logic [7:0]          opcode_q, opcode_d, len_lsb_q, len_lsb_d;
  logic [15:0]         rem_q, rem_d;
  logic [CW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d, operand_q, operand_d;
  logic [7:0]          echo_data_q, echo_data_d;
  logic                echo_valid_q, echo_valid_d;

  logic                rx_fire, tx_fire, err_pulse, div_start, div_done, last_byte;
  logic [15:0]         len, len_rem, rem_dec;
  logic [DATA_W-1:0]   operand_ins, div_quotient;
  logic [7:0]          tx_byte;

  seq_divider #(
    .WIDTH(DATA_W)
  ) u_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (div_start),
    .dividend_i(acc_q),
    .divisor_i (operand_q),
    .quotient_o(div_quotient),
    .done_o    (div_done)
  );

  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    unique case (state_q)
      StOpcode, StReserved, StLenLsb, StLenMsb, StFirstNumber, StRxNumber, StDrain:
        rx_ready_o = 1'b1;
      StEcho: begin
        rx_ready_o = !echo_valid_q;
        tx_valid_o = echo_valid_q;
        tx_data_o  = echo_data_q;
      end
      StTransmit: begin
        tx_valid_o = 1'b1;
        tx_data_o  = tx_byte;
      end
      default: ;
    endcase
    rx_ready_o = rx_ready_o && !rst_i;
    tx_valid_o = tx_valid_o && !rst_i;
  end

  assign busy_o  = (state_q != StOpcode) && !rst_i;
  assign err_o   = err_pulse && !rst_i;
  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;

  assign len       = {rx_data_i, len_lsb_q};
  assign len_rem   = (len < 16'(HDR_BYTES)) ? 16'd0 : len - 16'(HDR_BYTES);
  assign rem_dec   = rem_q - 16'd1;
  assign last_byte = (byte_cnt_q == LastByte);

  // Byte lane selected by byte_cnt: operand write during assembly, acc read during TRANSMIT.
  always_comb begin
    operand_ins = operand_q;
    tx_byte     = 8'h00;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (byte_cnt_q == CW'(i)) begin
        operand_ins[8*i +: 8] = rx_data_i;
        tx_byte               = acc_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    len_lsb_d    = len_lsb_q;
    rem_d        = rem_q;
    byte_cnt_d   = byte_cnt_q;
    acc_d        = acc_q;
    operand_d    = operand_q;
    echo_data_d  = echo_data_q;
    echo_valid_d = echo_valid_q;
    err_pulse    = 1'b0;
    div_start    = 1'b0;
    unique case (state_q)
      StOpcode: if (rx_fire) begin
        opcode_d = rx_data_i;
        state_d  = StReserved;
      end
      StReserved: if (rx_fire) state_d = StLenLsb;
      StLenLsb: if (rx_fire) begin
        len_lsb_d = rx_data_i;
        state_d   = StLenMsb;
      end
      StLenMsb: if (rx_fire) begin
        rem_d      = len_rem;
        byte_cnt_d = '0;
        acc_d      = '0;
        if (opcode_q == OPCODE_ECHO) begin
          state_d = (len_rem == 16'd0) ? StOpcode : StEcho;
        end else if (is_arith(opcode_q)) begin
          state_d = (len_rem == 16'd0) ? StTransmit : StFirstNumber;
        end else begin
          err_pulse = 1'b1;
          state_d   = (len_rem == 16'd0) ? StOpcode : StDrain;
        end
      end
      StEcho: begin
        if (rx_fire) begin
          echo_data_d  = rx_data_i;
          echo_valid_d = 1'b1;
          rem_d        = rem_dec;
        end else if (tx_fire) begin
          echo_valid_d = 1'b0;
          if (rem_q == 16'd0) state_d = StOpcode;
        end
      end
      StFirstNumber, StRxNumber: if (rx_fire) begin
        operand_d  = operand_ins;
        rem_d      = rem_dec;
        byte_cnt_d = last_byte ? '0 : byte_cnt_q + CW'(1);
        if (last_byte) begin
          if (state_q == StFirstNumber) begin
            acc_d   = operand_ins;
            state_d = (rem_dec == 16'd0) ? StTransmit : StRxNumber;
          end else begin
            state_d = op_state(opcode_q);
          end
        end else if (rem_dec == 16'd0) begin
          // Truncated operand: drop it and report what has been folded so far.
          byte_cnt_d = '0;
          state_d    = StTransmit;
        end
      end
      StAdd, StSub, StMul: begin
        if (state_q == StAdd)      acc_d = acc_q + operand_q;
        else if (state_q == StSub) acc_d = acc_q - operand_q;
        else                       acc_d = acc_q * operand_q;
        state_d = (rem_q == 16'd0) ? StTransmit : StRxNumber;
      end
      StDiv: begin
        div_start = 1'b1;
        state_d   = StDivWait;
      end
      StDivWait: if (div_done) begin
        acc_d   = div_quotient;
        state_d = (rem_q == 16'd0) ? StTransmit : StRxNumber;
      end
      StTransmit: if (tx_fire) begin
        byte_cnt_d = last_byte ? '0 : byte_cnt_q + CW'(1);
        if (last_byte) state_d = StOpcode;
      end
      StDrain: if (rx_fire) begin
        rem_d = rem_dec;
        if (rem_dec == 16'd0) state_d = StOpcode;
      end
      default: state_d = StOpcode;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StOpcode;
      opcode_q     <= 8'h00;
      len_lsb_q    <= 8'h00;
      rem_q        <= 16'd0;
      byte_cnt_q   <= '0;
      acc_q        <= '0;
      operand_q    <= '0;
      echo_data_q  <= 8'h00;
      echo_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      len_lsb_q    <= len_lsb_d;
      rem_q        <= rem_d;
      byte_cnt_q   <= byte_cnt_d;
      acc_q        <= acc_d;
      operand_q    <= operand_d;
      echo_data_q  <= echo_data_d;
      echo_valid_q <= echo_valid_d;
    end
  end

endmodule

// File: tb/tb_packet_alu.sv
// Self-checking bench for packet_alu (DATA_W=32): directed vectors, corner sequences, random packets.
module tb_packet_alu;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [127:0] pkt;
    int           n;
    logic [63:0]  exp;
    int           exp_n;
    int           err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       err;

  int compared = 0;
  int mismatched = 0;
  int gap_cycles, stall_cycles, stall_bad;

  packet_alu #(
    .DATA_W(32)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .tx_data_o (tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .busy_o    (busy),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  function automatic string q2s(input bq_t q);
    string s = "";
    for (int i = 0; i < q.size() && i < 24; i++) s = {s, $sformatf("%02h ", q[i])};
    if (q.size() > 24) s = {s, "..."};
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input bq_t act, input bq_t exp);
    bit bad = (act.size() != exp.size());
    for (int i = 0; i < act.size() && !bad; i++) if (act[i] !== exp[i]) bad = 1;
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL %s: got [%s], expected [%s]", name, q2s(act), q2s(exp));
    end
  endtask

  // Reference: parse header, then echo payload or fold whole 4-byte LE operands.
  function automatic void model(input bq_t pkt, output bq_t tx, output int e);
    int len, rem, nops;
    logic [31:0] acc, op;
    tx = {};
    e = 0;
    len = int'({pkt[3], pkt[2]});
    rem = (len < 4) ? 0 : len - 4;
    case (pkt[0])
      8'hEC: for (int i = 0; i < rem; i++) tx.push_back(pkt[4+i]);
      8'hAD, 8'h5B, 8'h88, 8'hD1: begin
        nops = rem / 4;
        acc = 0;
        for (int k = 0; k < nops; k++) begin
          op = {pkt[4+4*k+3], pkt[4+4*k+2], pkt[4+4*k+1], pkt[4+4*k]};
          if (k == 0) acc = op;
          else if (pkt[0] == 8'hAD) acc = acc + op;
          else if (pkt[0] == 8'h5B) acc = acc - op;
          else if (pkt[0] == 8'h88) acc = acc * op;
          else acc = (op == 0) ? 32'hFFFF_FFFF : acc / op;
        end
        for (int b = 0; b < 4; b++) tx.push_back(acc[8*b +: 8]);
      end
      default: e = 1;
    endcase
  endfunction

  // Drives one packet; mode 0: tx always ready, 1: random ready, 2: ten-cycle stall after first byte.
  task automatic run_packet(input bq_t pkt, input int mode, input bit stop_after_rx,
                            output bq_t got, output int errs);
    int idx = 0, cyc = 0, last_rx = -1, first_tx = -1, limit;
    bit prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    got = {};
    errs = 0;
    stall_cycles = 0;
    stall_bad = 0;
    limit = 400 + 50 * pkt.size();
    do begin
      @(negedge clk);
      rx_valid = (idx < pkt.size());
      rx_data  = rx_valid ? pkt[idx] : 8'h00;
      case (mode)
        1:       tx_ready = ($urandom_range(0, 3) != 0);
        2:       tx_ready = !(first_tx >= 0 && cyc - first_tx < 11);
        default: tx_ready = 1'b1;
      endcase
      #1;
      if (rx_valid && rx_ready) begin
        idx++;
        if (idx == pkt.size()) last_rx = cyc;
      end
      if (tx_valid && first_tx < 0) first_tx = cyc;
      if (prev_stall && tx_data !== prev_data) stall_bad++;
      prev_stall = tx_valid && !tx_ready;
      if (prev_stall) stall_cycles++;
      prev_data = tx_data;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (err) errs++;
      cyc++;
    end while (cyc < limit && (idx < pkt.size() || (!stop_after_rx && busy)));
    if (cyc >= limit) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: packet %0h not completed in %0d cycles", pkt[0], limit);
    end
    gap_cycles = (last_rx >= 0 && first_tx > last_rx) ? first_tx - last_rx - 1 : -1;
    @(negedge clk);
    rx_valid = 1'b0;
    tx_ready = 1'b1;
  endtask

  initial begin
    vec_t vecs[$];
    bq_t pkt, got, exp;
    int errs, exp_err, txv;

    vecs.push_back('{128'hEC00_0700_4142_43, 7, 64'h4142_43, 3, 0});
    vecs.push_back('{128'hAD00_0C00_0100_0000_0200_0000, 12, 64'h0300_0000, 4, 0});
    vecs.push_back('{128'h5B00_0C00_0100_0000_0200_0000, 12, 64'hFFFF_FFFF, 4, 0});
    vecs.push_back('{128'h8800_0C00_0000_0100_0000_0100, 12, 64'h0000_0000, 4, 0});
    vecs.push_back('{128'hD100_0C00_6400_0000_0700_0000, 12, 64'h0E00_0000, 4, 0});
    vecs.push_back('{128'hD100_0C00_6400_0000_0000_0000, 12, 64'hFFFF_FFFF, 4, 0});
    vecs.push_back('{128'h4200_0600_AABB, 6, 64'h0, 0, 1});
    vecs.push_back('{128'hEC00_0500_5A, 5, 64'h5A, 1, 0});
    vecs.push_back('{128'hEC00_0400, 4, 64'h0, 0, 0});
    vecs.push_back('{128'hAD00_0400, 4, 64'h0000_0000, 4, 0});
    vecs.push_back('{128'hAD00_0200, 4, 64'h0000_0000, 4, 0});
    vecs.push_back('{128'hAD00_0E00_0500_0000_0300_0000_7788, 14, 64'h0800_0000, 4, 0});
    vecs.push_back('{128'h8800_0800_1234_5678, 8, 64'h1234_5678, 4, 0});
    vecs.push_back('{128'hAD00_1000_FFFF_FFFF_0200_0000_0300_0000, 16, 64'h0400_0000, 4, 0});
    vecs.push_back('{128'h0000_0400, 4, 64'h0, 0, 1});

    // Reset state
    #2;
    check("reset_outputs", {60'h0, tx_valid, rx_ready, busy, err}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_idle", {61'h0, tx_valid, rx_ready, busy}, 64'h2);

    foreach (vecs[v]) begin
      pkt = {};
      exp = {};
      for (int i = 0; i < vecs[v].n; i++) pkt.push_back(vecs[v].pkt[8*(vecs[v].n-1-i) +: 8]);
      for (int i = 0; i < vecs[v].exp_n; i++)
        exp.push_back(vecs[v].exp[8*(vecs[v].exp_n-1-i) +: 8]);
      run_packet(pkt, 0, 0, got, errs);
      check_q($sformatf("vec%0d_tx", v), got, exp);
      check($sformatf("vec%0d_err", v), 64'(errs), 64'(vecs[v].err));
      check($sformatf("vec%0d_idle", v), {63'h0, busy}, 64'h0);
      if (v == 5) check("div0_latency", 64'(gap_cycles), 64'd33);
    end

    // Backpressure mid-TRANSMIT
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
    run_packet(pkt, 2, 0, got, errs);
    exp = '{8'h55, 8'h44, 8'h33, 8'h22};
    check_q("backpressure_tx", got, exp);
    check("backpressure_stalled", 64'(stall_cycles >= 10), 64'd1);
    check("backpressure_stable", 64'(stall_bad), 64'd0);

    // Reset while dividing
    pkt = '{8'hD1, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    run_packet(pkt, 0, 1, got, errs);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("div_reset_outputs", {60'h0, tx_valid, rx_ready, busy, err}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    txv = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (tx_valid) txv++;
    end
    check("div_reset_no_tx", 64'(txv + got.size()), 64'd0);
    check("div_reset_idle", {63'h0, busy}, 64'h0);
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    run_packet(pkt, 0, 0, got, errs);
    exp = '{8'h30, 8'h00, 8'h00, 8'h00};
    check_q("add_after_reset", got, exp);

    // Random packets against the reference model
    for (int p = 0; p < 40; p++) begin
      logic [7:0] op;
      int len, plen;
      case ($urandom_range(0, 5))
        0: op = 8'hEC;
        1: op = 8'hAD;
        2: op = 8'h5B;
        3: op = 8'h88;
        4: op = 8'hD1;
        default: begin
          do op = 8'($urandom_range(0, 255));
          while (op == 8'hEC || op == 8'hAD || op == 8'h5B || op == 8'h88 || op == 8'hD1);
        end
      endcase
      if ($urandom_range(0, 7) == 0) begin
        len = $urandom_range(0, 4);
        plen = 0;
      end else begin
        plen = $urandom_range(0, 14);
        len = plen + 4;
      end
      pkt = {op, 8'($urandom_range(0, 255)), 8'(len), 8'(len >> 8)};
      for (int i = 0; i < plen; i++) pkt.push_back(8'($urandom_range(0, 255)));
      model(pkt, exp, exp_err);
      run_packet(pkt, int'($urandom_range(0, 1)), 0, got, errs);
      check_q($sformatf("rand%0d_tx", p), got, exp);
      check($sformatf("rand%0d_err", p), 64'(errs), 64'(exp_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
